// File: rtl/intr_ctrl.sv
// intr_ctrl: N-channel priority interrupt controller (edge/level, mask, pending, in-service, vector, EOI).
// Define INTR_NEST_EN to let higher-priority requests preempt an interrupt already in service.
module intr_ctrl #(
  parameter int unsigned N_CH     = 8,
  parameter int unsigned VEC_W    = 8,
  parameter int unsigned VEC_BASE = 32
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [N_CH-1:0]  Irq,
  input  logic [N_CH-1:0]  Edge_mode,
  input  logic             Mask_we,
  input  logic [N_CH-1:0]  Mask_wdata,
  output logic [N_CH-1:0]  Mask,
  output logic [N_CH-1:0]  Pending,
  output logic [N_CH-1:0]  In_service,
  output logic             Intr,
  input  logic             Inta,
  output logic [VEC_W-1:0] Vector,
  input  logic             Eoi
);
  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;
  state_t state, state_next;

  logic [N_CH-1:0]  irq_prev;
  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  is_lowest;
  logic [N_CH-1:0]  is_after_eoi;
  logic [N_CH-1:0]  prio_window;
  logic [N_CH-1:0]  eligible;
  logic [N_CH-1:0]  grant_onehot;
  logic [N_CH-1:0]  pending_next;
  logic [IDX_W-1:0] grant_idx;
  logic             any_eligible;
  logic             grant;
  logic             spurious;

  assign rise         = Irq & ~irq_prev;
  assign is_lowest    = In_service & (~In_service + N_CH'(1));
  assign is_after_eoi = Eoi ? (In_service & ~is_lowest) : In_service;

`ifdef INTR_NEST_EN
  // Only channels above the highest-priority in-service one may preempt (all when none in service).
  assign prio_window = is_lowest - N_CH'(1);
`else
  assign prio_window = (In_service == '0) ? '1 : '0;
`endif

  assign eligible     = Pending & ~Mask & ~In_service & prio_window;
  assign any_eligible = |eligible;

  // Lowest-index eligible channel wins.
  always_comb begin
    grant_idx = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (eligible[i]) grant_idx = IDX_W'(i);
    end
  end

  assign grant_onehot = grant ? (N_CH'(1) << grant_idx) : '0;

  // Edge channels latch rises until acknowledged; level channels track the input.
  assign pending_next = (Edge_mode & ((Pending & ~grant_onehot) | rise)) | (~Edge_mode & Irq);

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    spurious   = 1'b0;
    case (state)
      IDLE: begin
        if (any_eligible) state_next = REQ;
      end
      REQ: begin
        if (Inta && any_eligible) begin
          grant      = 1'b1;
          state_next = SERV;
        end else if (Inta || !any_eligible) begin
          spurious   = Inta;
          state_next = (is_after_eoi != '0) ? SERV : IDLE;
        end
      end
      SERV: begin
        if (is_after_eoi == '0) state_next = IDLE;
`ifdef INTR_NEST_EN
        else if (any_eligible) state_next = REQ;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state      <= IDLE;
      irq_prev   <= '0;
      Mask       <= '1;
      Pending    <= '0;
      In_service <= '0;
      Intr       <= 1'b0;
      Vector     <= '0;
    end else begin
      state      <= state_next;
      irq_prev   <= Irq;
      Pending    <= pending_next;
      In_service <= is_after_eoi | grant_onehot;
      Intr       <= (state_next == REQ);
      if (Mask_we) Mask <= Mask_wdata;
      if (grant) Vector <= VEC_W'(VEC_BASE + 32'(grant_idx));
      else if (spurious) Vector <= '1;
    end
  end
endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_intr_ctrl;
  localparam int N  = 8;
  localparam int VB = 32;
`ifdef INTR_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic         clk        = 1'b0;
  logic         clr        = 1'b1;
  logic [N-1:0] irq        = '0;
  logic [N-1:0] edge_mode  = '0;
  logic         mask_we    = 1'b0;
  logic [N-1:0] mask_wdata = '0;
  logic         inta       = 1'b0;
  logic         eoi        = 1'b0;
  logic [N-1:0] mask, pending, in_service;
  logic         intr;
  logic [7:0]   vector;

  int checks   = 0;
  int failures = 0;

  intr_ctrl #(.N_CH(N), .VEC_W(8), .VEC_BASE(VB)) dut (
    .Clk(clk), .Clr(clr), .Irq(irq), .Edge_mode(edge_mode),
    .Mask_we(mask_we), .Mask_wdata(mask_wdata), .Mask(mask),
    .Pending(pending), .In_service(in_service), .Intr(intr),
    .Inta(inta), .Vector(vector), .Eoi(eoi)
  );

  always #5 clk = ~clk;

  // Behavioural reference model (phase: 0 idle, 1 requesting, 2 servicing)
  logic [N-1:0] m_mask = '1, m_pend = '0, m_isv = '0, m_prev = '0;
  logic [7:0]   m_vec  = '0;
  logic         m_intr = 1'b0;
  int           m_phase = 0;

  function automatic int first_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge clr) begin : model
    logic [N-1:0] elig, isv, pend;
    logic [7:0]   vec;
    int           k, top, ph;
    if (clr) begin
      m_mask <= '1; m_pend <= '0; m_isv <= '0; m_prev <= '0;
      m_vec <= '0; m_intr <= 1'b0; m_phase <= 0;
    end else begin
      elig = m_pend & ~m_mask & ~m_isv;
      top  = first_set(m_isv);
      if (top >= 0) begin
        if (NEST) begin
          for (int i = 0; i < N; i++) if (i >= top) elig[i] = 1'b0;
        end else begin
          elig = '0;
        end
      end
      k   = first_set(elig);
      isv = m_isv;
      if (eoi && top >= 0) isv[top] = 1'b0;
      for (int i = 0; i < N; i++)
        pend[i] = edge_mode[i] ? (m_pend[i] | (irq[i] & ~m_prev[i])) : irq[i];
      ph  = m_phase;
      vec = m_vec;
      case (m_phase)
        0: if (k >= 0) ph = 1;
        1: begin
          if (inta && k >= 0) begin
            vec = 8'(VB + k);
            isv[k] = 1'b1;
            if (edge_mode[k] && !(irq[k] && !m_prev[k])) pend[k] = 1'b0;
            ph = 2;
          end else if (inta) begin
            vec = 8'hFF;
            ph = (isv != 0) ? 2 : 0;
          end else if (k < 0) begin
            ph = (isv != 0) ? 2 : 0;
          end
        end
        default: begin
          if (isv == 0) ph = 0;
          else if (NEST && k >= 0) ph = 1;
        end
      endcase
      if (mask_we) m_mask <= mask_wdata;
      m_pend <= pend; m_isv <= isv; m_prev <= irq;
      m_vec <= vec; m_phase <= ph; m_intr <= (ph == 1);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #10; clr = 1'b0; #1;
    checks++;
    if ({intr, vector, mask, pending, in_service} !== {1'b0, 8'h00, 8'hFF, 8'h00, 8'h00}) begin
      failures++;
      $display("FAIL reset: intr=%b vec=%h mask=%h pend=%h isv=%h, want 0/00/ff/00/00", intr, vector, mask, pending, in_service);
    end
    tick();
    checks++;
    if ({intr, in_service} !== {1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_idle: intr=%b isv=%h, want 0/00", intr, in_service);
    end
  endtask

  task automatic test_edge_basic();
    mask_we = 1'b1; mask_wdata = '0; edge_mode = 8'h08; tick(); mask_we = 1'b0;
    checks++;
    if (mask !== 8'h00) begin failures++; $display("FAIL mask_write: mask=%h want 00", mask); end
    irq = 8'h08; tick(); irq = '0;
    checks++;
    if ({pending, intr} !== {8'h08, 1'b0}) begin
      failures++; $display("FAIL edge_pend: pend=%h intr=%b want 08/0", pending, intr);
    end
    tick();
    checks++;
    if (intr !== 1'b1) begin failures++; $display("FAIL edge_intr: intr=%b want 1", intr); end
    inta = 1'b1; tick(); inta = 1'b0;
    checks++;
    if ({vector, in_service, pending, intr} !== {8'd35, 8'h08, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL edge_ack: vec=%0d isv=%h pend=%h intr=%b want 35/08/00/0", vector, in_service, pending, intr);
    end
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++;
    if ({in_service, intr} !== {8'h00, 1'b0}) begin
      failures++; $display("FAIL edge_eoi: isv=%h intr=%b want 00/0", in_service, intr);
    end
    tick();
    checks++;
    if (intr !== 1'b0) begin failures++; $display("FAIL edge_idle: intr=%b want 0", intr); end
  endtask

  task automatic test_priority();
    edge_mode = 8'hFF;
    irq = 8'h24; tick(); irq = '0; tick();
    checks++;
    if ({intr, pending} !== {1'b1, 8'h24}) begin
      failures++; $display("FAIL prio_req: intr=%b pend=%h want 1/24", intr, pending);
    end
    inta = 1'b1; tick(); inta = 1'b0;
    checks++;
    if ({vector, in_service, pending, intr} !== {8'd34, 8'h04, 8'h20, 1'b0}) begin
      failures++;
      $display("FAIL prio_first: vec=%0d isv=%h pend=%h intr=%b want 34/04/20/0", vector, in_service, pending, intr);
    end
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++;
    if ({in_service, intr} !== {8'h00, 1'b0}) begin
      failures++; $display("FAIL prio_eoi1: isv=%h intr=%b want 00/0", in_service, intr);
    end
    tick();
    checks++;
    if (intr !== 1'b1) begin failures++; $display("FAIL prio_rereq: intr=%b want 1", intr); end
    inta = 1'b1; tick(); inta = 1'b0;
    checks++;
    if ({vector, in_service, pending} !== {8'd37, 8'h20, 8'h00}) begin
      failures++;
      $display("FAIL prio_second: vec=%0d isv=%h pend=%h want 37/20/00", vector, in_service, pending);
    end
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++;
    if (in_service !== 8'h00) begin failures++; $display("FAIL prio_eoi2: isv=%h want 00", in_service); end
  endtask

  task automatic test_level_rescind();
    edge_mode = 8'h00;
    irq = 8'h02; tick();
    checks++;
    if ({pending, intr} !== {8'h02, 1'b0}) begin
      failures++; $display("FAIL lvl_pend: pend=%h intr=%b want 02/0", pending, intr);
    end
    tick();
    checks++;
    if (intr !== 1'b1) begin failures++; $display("FAIL lvl_req: intr=%b want 1", intr); end
    irq = '0; tick();
    checks++;
    if ({pending, intr} !== {8'h00, 1'b1}) begin
      failures++; $display("FAIL lvl_drop: pend=%h intr=%b want 00/1", pending, intr);
    end
    tick();
    checks++;
    if ({intr, in_service, vector} !== {1'b0, 8'h00, 8'd37}) begin
      failures++; $display("FAIL lvl_rescind: intr=%b isv=%h vec=%0d want 0/00/37", intr, in_service, vector);
    end
    inta = 1'b1; tick(); inta = 1'b0;
    checks++;
    if ({intr, in_service, vector} !== {1'b0, 8'h00, 8'd37}) begin
      failures++; $display("FAIL inta_idle: intr=%b isv=%h vec=%0d want 0/00/37", intr, in_service, vector);
    end
    irq = 8'h02; tick(); tick();
    irq = '0; tick();
    inta = 1'b1; tick(); inta = 1'b0;
    checks++;
    if ({vector, in_service, intr} !== {8'hFF, 8'h00, 1'b0}) begin
      failures++; $display("FAIL spurious: vec=%h isv=%h intr=%b want ff/00/0", vector, in_service, intr);
    end
  endtask

  task automatic test_mask();
    edge_mode = 8'h10;
    mask_we = 1'b1; mask_wdata = 8'h10; tick(); mask_we = 1'b0;
    irq = 8'h10; tick(); irq = '0; tick(); tick();
    checks++;
    if ({pending, intr} !== {8'h10, 1'b0}) begin
      failures++; $display("FAIL mask_hold: pend=%h intr=%b want 10/0", pending, intr);
    end
    mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0;
    checks++;
    if ({mask, intr} !== {8'h00, 1'b0}) begin
      failures++; $display("FAIL unmask_old: mask=%h intr=%b want 00/0", mask, intr);
    end
    tick();
    checks++;
    if (intr !== 1'b1) begin failures++; $display("FAIL unmask_req: intr=%b want 1", intr); end
    mask_we = 1'b1; mask_wdata = 8'h10; tick(); mask_we = 1'b0;
    checks++;
    if ({mask, intr} !== {8'h10, 1'b1}) begin
      failures++; $display("FAIL mask_in_req: mask=%h intr=%b want 10/1", mask, intr);
    end
    tick();
    checks++;
    if ({intr, pending} !== {1'b0, 8'h10}) begin
      failures++; $display("FAIL mask_drop: intr=%b pend=%h want 0/10", intr, pending);
    end
    mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0; tick();
    inta = 1'b1; tick(); inta = 1'b0;
    checks++;
    if ({vector, in_service, pending} !== {8'd36, 8'h10, 8'h00}) begin
      failures++; $display("FAIL mask_ack: vec=%0d isv=%h pend=%h want 36/10/00", vector, in_service, pending);
    end
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic test_nest();
    edge_mode = 8'hFF;
    irq = 8'h40; tick(); irq = '0; tick();
    inta = 1'b1; tick(); inta = 1'b0;
    checks++;
    if ({vector, in_service, intr} !== {8'd38, 8'h40, 1'b0}) begin
      failures++; $display("FAIL nest_ch6: vec=%0d isv=%h intr=%b want 38/40/0", vector, in_service, intr);
    end
    irq = 8'h01; tick(); irq = '0;
    checks++;
    if ({pending, intr} !== {8'h01, 1'b0}) begin
      failures++; $display("FAIL nest_pend: pend=%h intr=%b want 01/0", pending, intr);
    end
    tick();
`ifdef INTR_NEST_EN
    checks++;
    if (intr !== 1'b1) begin failures++; $display("FAIL nest_req: intr=%b want 1", intr); end
    inta = 1'b1; tick(); inta = 1'b0;
    checks++;
    if ({vector, in_service, intr} !== {8'd32, 8'h41, 1'b0}) begin
      failures++; $display("FAIL nest_ack: vec=%0d isv=%h intr=%b want 32/41/0", vector, in_service, intr);
    end
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++;
    if (in_service !== 8'h40) begin failures++; $display("FAIL nest_eoi1: isv=%h want 40", in_service); end
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++;
    if ({in_service, intr} !== {8'h00, 1'b0}) begin
      failures++; $display("FAIL nest_eoi2: isv=%h intr=%b want 00/0", in_service, intr);
    end
`else
    checks++;
    if (intr !== 1'b0) begin failures++; $display("FAIL nonest_block: intr=%b want 0", intr); end
    tick();
    checks++;
    if ({intr, in_service, pending} !== {1'b0, 8'h40, 8'h01}) begin
      failures++; $display("FAIL nonest_hold: intr=%b isv=%h pend=%h want 0/40/01", intr, in_service, pending);
    end
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++;
    if ({in_service, intr} !== {8'h00, 1'b0}) begin
      failures++; $display("FAIL nonest_eoi: isv=%h intr=%b want 00/0", in_service, intr);
    end
    tick();
    checks++;
    if (intr !== 1'b1) begin failures++; $display("FAIL nonest_req: intr=%b want 1", intr); end
    inta = 1'b1; tick(); inta = 1'b0;
    checks++;
    if ({vector, in_service} !== {8'd32, 8'h01}) begin
      failures++; $display("FAIL nonest_ack: vec=%0d isv=%h want 32/01", vector, in_service);
    end
    eoi = 1'b1; tick(); eoi = 1'b0;
`endif
  endtask

  task automatic test_clr_mid();
    edge_mode = 8'hFF;
    irq = 8'h04; tick(); irq = '0; tick();
    checks++;
    if (intr !== 1'b1) begin failures++; $display("FAIL clr_setup: intr=%b want 1", intr); end
    inta = 1'b1; eoi = 1'b1;
    #2 clr = 1'b1;
    #1;
    checks++;
    if ({intr, vector, mask, pending, in_service} !== {1'b0, 8'h00, 8'hFF, 8'h00, 8'h00}) begin
      failures++;
      $display("FAIL clr_async: intr=%b vec=%h mask=%h pend=%h isv=%h want 0/00/ff/00/00", intr, vector, mask, pending, in_service);
    end
    tick(); inta = 1'b0; eoi = 1'b0; clr = 1'b0; tick();
    checks++;
    if ({intr, vector, in_service} !== {1'b0, 8'h00, 8'h00}) begin
      failures++; $display("FAIL clr_after: intr=%b vec=%h isv=%h want 0/00/00", intr, vector, in_service);
    end
    mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      checks++;
      if ({intr, vector, mask, pending, in_service} !== {m_intr, m_vec, m_mask, m_pend, m_isv}) begin
        failures++;
        $display("FAIL random c%0d: dut intr=%b vec=%h mask=%h pend=%h isv=%h model intr=%b vec=%h mask=%h pend=%h isv=%h",
                 c, intr, vector, mask, pending, in_service, m_intr, m_vec, m_mask, m_pend, m_isv);
      end
      if (c % 500 == 0) edge_mode = N'($urandom);
      irq        = N'($urandom & $urandom & $urandom);
      mask_we    = ($urandom_range(0, 15) == 0);
      mask_wdata = N'($urandom & $urandom & $urandom);
      inta       = m_intr ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 31) == 0);
      eoi        = ($urandom_range(0, 5) == 0);
      tick();
    end
    irq = '0; mask_we = 1'b0; inta = 1'b0; eoi = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_priority();
    test_level_rescind();
    test_mask();
    test_nest();
    test_clr_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
